av2_recon_adder: RTL and testbench

Reconstruction stage directly downstream of the inverse transform. It joins the residual stream (inverse-transform output) with the intra/inter prediction stream, adds them lane-wise, and clips to the pixel range. It emits reconstructed samples in raster order, with a block-end marker, toward the loop-filter/frame-buffer writer. It processes one transform block per `start`, with a single registered output stage and full valid/ready backpressure.

---
 rtl/av2_recon_adder.sv | 214 +++++++++++++++++++++
 tb/tb_av2_recon_adder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/av2_recon_adder.sv
// av2_recon_adder: joins residual and prediction beats, adds them lane-wise and clips to the pixel range.
// Optional feature macro: AV2_RECON_SAT_CNT_EN enables the per-block clipped-sample counter on sat_count.
module av2_recon_adder #(
    parameter int BIT_DEPTH = 10,
    parameter int LANES     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [6:0]                 blk_w,
    input  logic [6:0]                 blk_h,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [16*LANES-1:0]        res_data,
    input  logic                       pred_valid,
    output logic                       pred_ready,
    input  logic [BIT_DEPTH*LANES-1:0] pred_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_DEPTH*LANES-1:0] out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    output logic [12:0]                sat_count
);
    localparam int LANE_SH = $clog2(LANES);
    localparam int CNT_W   = 13 - LANE_SH;
    localparam logic signed [17:0] PIX_MAX_S = 18'((1 << BIT_DEPTH) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           total_q, total_d;
    logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic [BIT_DEPTH*LANES-1:0] out_data_q, out_data_d;
    logic                       done_q, done_d;
    logic                       cfg_err_q, cfg_err_d;
    logic [BIT_DEPTH*LANES-1:0] recon_s;
    logic                       size_ok_s;
    logic                       out_free_s;
    logic                       fire_s;
    logic                       last_beat_s;
`ifdef AV2_RECON_SAT_CNT_EN
    logic [LANES-1:0]           clip_s;
`endif

    function automatic logic size_legal(input logic [6:0] sz);
        case (sz)
            7'd4, 7'd8, 7'd16, 7'd32, 7'd64: size_legal = 1'b1;
            default:                          size_legal = 1'b0;
        endcase
    endfunction

    // Per-lane add at 18 bits signed, then clip to [0, 2^BIT_DEPTH-1].
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [17:0] sum_s;
        assign sum_s = $signed({{(18-BIT_DEPTH){1'b0}}, pred_data[l*BIT_DEPTH +: BIT_DEPTH]})
                     + $signed({{2{res_data[l*16+15]}}, res_data[l*16 +: 16]});
        assign recon_s[l*BIT_DEPTH +: BIT_DEPTH] =
            sum_s[17]           ? {BIT_DEPTH{1'b0}} :
            (sum_s > PIX_MAX_S) ? PIX_MAX_S[BIT_DEPTH-1:0] :
                                  sum_s[BIT_DEPTH-1:0];
`ifdef AV2_RECON_SAT_CNT_EN
        assign clip_s[l] = sum_s[17] || (sum_s > PIX_MAX_S);
`endif
    end

    // Both streams are consumed together, and only when the output register can take the beat.
    assign out_free_s  = !out_valid_q || out_ready;
    assign size_ok_s   = size_legal(blk_w) && size_legal(blk_h);
    assign res_ready   = (state_q == S_RUN) && pred_valid && out_free_s;
    assign pred_ready  = (state_q == S_RUN) && res_valid && out_free_s;
    assign fire_s      = (state_q == S_RUN) && res_valid && pred_valid && out_free_s;
    assign last_beat_s = (beat_cnt_q == (total_q - CNT_W'(1)));

    // Next-state logic for the block sequencer.
    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && size_ok_s) begin
                    state_d    = S_RUN;
                    total_d    = CNT_W'(({6'b0, blk_w} * {6'b0, blk_h}) >> LANE_SH);
                    beat_cnt_d = {CNT_W{1'b0}};
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (fire_s) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_beat_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: load on fire, clear valid on drain, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (fire_s) begin
            out_valid_d = 1'b1;
            out_last_d  = last_beat_s;
            out_data_d  = recon_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            total_q     <= {CNT_W{1'b0}};
            beat_cnt_q  <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {(BIT_DEPTH*LANES){1'b0}};
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

`ifdef AV2_RECON_SAT_CNT_EN
    logic [12:0] sat_q, sat_d;
    logic [13:0] sat_sum_s;

    function automatic logic [13:0] clip_total(input logic [LANES-1:0] f);
        logic [13:0] n;
        n = 14'd0;
        for (int i = 0; i < LANES; i++) begin
            n = n + 14'(f[i]);
        end
        return n;
    endfunction

    // Clipped-sample counter: cleared on accepted start, saturating at 8191.
    always_comb begin
        sat_sum_s = {1'b0, sat_q} + clip_total(clip_s);
        if ((state_q == S_IDLE) && start && size_ok_s) begin
            sat_d = 13'd0;
        end else if (fire_s) begin
            sat_d = (sat_sum_s > 14'd8191) ? 13'd8191 : sat_sum_s[12:0];
        end else begin
            sat_d = sat_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 13'd0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = 13'd0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_av2_recon_adder.sv
// Self-checking bench for av2_recon_adder: table vectors, randomized blocks against a behavioural model,
// and hand sequences for illegal size and mid-block reset.
`timescale 1ns/1ps
module tb_av2_recon_adder;
    localparam int BD   = 10;
    localparam int LN   = 4;
    localparam int PMAX = (1 << BD) - 1;
    localparam int DW   = BD * LN;
    localparam int RW   = 16 * LN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [6:0]    blk_w = 7'd4;
    logic [6:0]    blk_h = 7'd4;
    logic          res_valid = 1'b0;
    logic          pred_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [RW-1:0] res_data = '0;
    logic [DW-1:0] pred_data = '0;
    logic          res_ready, pred_ready, out_valid, out_last, busy, done, cfg_err;
    logic [DW-1:0] out_data;
    logic [12:0]   sat_count;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [RW-1:0] q_res[$];
    logic [DW-1:0] q_pred[$];
    logic [DW:0]   q_exp[$];

    typedef struct {
        logic [DW-1:0] pred;
        logic [RW-1:0] res;
        logic [DW-1:0] exp;
        int            clips;
    } vec_t;
    vec_t tbl[8];

    av2_recon_adder #(.BIT_DEPTH(BD), .LANES(LN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .blk_w(blk_w), .blk_h(blk_h),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_data(pred_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .cfg_err(cfg_err), .sat_count(sat_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] p4(input int a, input int b, input int c, input int d);
        return {BD'(d), BD'(c), BD'(b), BD'(a)};
    endfunction

    function automatic logic [RW-1:0] r4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Reference: integer add of unsigned prediction and signed residual, clipped to pixel range.
    function automatic logic [DW-1:0] recon_model(input logic [DW-1:0] p, input logic [RW-1:0] r,
                                                  output int nclip);
        logic [DW-1:0] o;
        int pv, rv, s;
        o = '0;
        nclip = 0;
        for (int l = 0; l < LN; l++) begin
            pv = int'(p[l*BD +: BD]);
            rv = int'($signed(r[l*16 +: 16]));
            s  = pv + rv;
            if (s < 0) begin
                s = 0;
                nclip++;
            end else if (s > PMAX) begin
                s = PMAX;
                nclip++;
            end
            o[l*BD +: BD] = BD'(s);
        end
        return o;
    endfunction

    task automatic fill_random(input int total, output int clips);
        logic [DW-1:0] p, e;
        logic [RW-1:0] r;
        int rv[LN];
        int n;
        clips = 0;
        for (int i = 0; i < total; i++) begin
            for (int l = 0; l < LN; l++) begin
                case ($urandom_range(0, 7))
                    0:       rv[l] = 32767;
                    1:       rv[l] = -32768;
                    default: rv[l] = int'($urandom_range(0, 2400)) - 1200;
                endcase
            end
            p = p4(int'($urandom_range(0, PMAX)), int'($urandom_range(0, PMAX)),
                   int'($urandom_range(0, PMAX)), int'($urandom_range(0, PMAX)));
            r = r4(rv[0], rv[1], rv[2], rv[3]);
            e = recon_model(p, r, n);
            clips += n;
            q_pred.push_back(p);
            q_res.push_back(r);
            q_exp.push_back({(i == total - 1), e});
        end
    endtask

    // Runs one block from the queues. mode 0: full rate; mode 1: random valids/ready and stray starts.
    task automatic run_block(input string nm, input int w, input int h, input int mode,
                             input int abort_at, input int exp_sat);
        int total, nin, nout, start_cyc, done_cyc, last_cyc, sat_req;
        bit stalled, held_last, finished, lastfired, rf, pf, of;
        logic [DW-1:0] held_d;
        total = w * h / LN;
        nin = 0; nout = 0; done_cyc = -1; last_cyc = -100;
        stalled = 1'b0; held_last = 1'b0; finished = 1'b0; lastfired = 1'b0; held_d = '0;
`ifdef AV2_RECON_SAT_CNT_EN
        sat_req = exp_sat;
`else
        sat_req = 0;
`endif
        @(negedge clk);
        start = 1'b1; blk_w = 7'(w); blk_h = 7'(h);
        res_valid = 1'b0; pred_valid = 1'b0; out_ready = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < 20 * total + 50 && !finished; k++) begin
            @(negedge clk);
            if (mode == 1 && !lastfired) begin
                start = ($urandom_range(0, 3) == 0);
                blk_w = 7'd8; blk_h = 7'd8;
            end else begin
                start = 1'b0;
            end
            if (nin < total) begin
                res_data  = q_res[nin];
                pred_data = q_pred[nin];
            end
            if (mode == 0) begin
                res_valid = (nin < total); pred_valid = (nin < total); out_ready = 1'b1;
            end else begin
                res_valid  = (nin < total) && ($urandom_range(0, 2) != 0);
                pred_valid = (nin < total) && ($urandom_range(0, 2) != 0);
                out_ready  = ($urandom_range(0, 2) != 0);
            end
            #1;
            if (k == 0) chk({nm, "_busy"}, busy, 1);
            if (abort_at >= 0 && nin == abort_at) begin
                rst_n = 1'b0;
                finished = 1'b1;
            end else begin
                if (stalled) chk({nm, "_stall_hold"}, {out_valid, out_last, out_data}, {1'b1, held_last, held_d});
                rf = res_valid && res_ready;
                pf = pred_valid && pred_ready;
                of = out_valid && out_ready;
                if (rf != pf) chk({nm, "_joint_fire"}, rf, pf);
                if (of) begin
                    if (nout < total) begin
                        chk({nm, "_out_data"}, out_data, q_exp[nout][DW-1:0]);
                        chk({nm, "_out_last"}, out_last, q_exp[nout][DW]);
                    end else begin
                        chk({nm, "_extra_beat"}, nout, total - 1);
                    end
                    if (out_last) begin
                        last_cyc = cyc;
                        lastfired = 1'b1;
                    end
                    nout++;
                end
                if (done) begin
                    if (done_cyc < 0) begin
                        done_cyc = cyc;
                        chk({nm, "_done_after_last"}, cyc, last_cyc + 1);
                        chk({nm, "_beats_out"}, nout, total);
                        chk({nm, "_sat_count"}, sat_count, sat_req);
                        if (mode == 0) chk({nm, "_done_latency"}, cyc - start_cyc, total + 2);
                    end else begin
                        chk({nm, "_done_width"}, 1, 0);
                        finished = 1'b1;
                    end
                end else if (done_cyc >= 0) begin
                    chk({nm, "_idle_busy"}, busy, 0);
                    chk({nm, "_idle_valid"}, out_valid, 0);
                    finished = 1'b1;
                end
                stalled   = out_valid && !out_ready;
                held_d    = out_data;
                held_last = out_last;
                if (rf) nin++;
            end
        end
        if (abort_at < 0 && done_cyc < 0) chk({nm, "_timeout_done"}, 0, 1);
        start = 1'b0; res_valid = 1'b0; pred_valid = 1'b0;
        q_res.delete(); q_pred.delete(); q_exp.delete();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_res_ready"}, res_ready, 0);
        chk({nm, "_pred_ready"}, pred_ready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_out_data"}, out_data, 0);
        chk({nm, "_out_last"}, out_last, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_cfg_err"}, cfg_err, 0);
        chk({nm, "_sat_count"}, sat_count, 0);
    endtask

    initial begin
        int clips;
        int bad_w[5];
        int bad_h[5];
        bad_w = '{12, 2, 0, 96, 4};
        bad_h = '{8, 8, 4, 4, 127};
        tbl[0] = '{p4(1000, 5, 0, 1023), r4(100, -20, -32768, 32767), p4(1023, 0, 0, 1023), 4};
        tbl[1] = '{p4(512, 512, 512, 512), r4(3, 3, 3, 3), p4(515, 515, 515, 515), 0};
        tbl[2] = '{p4(1023, 0, 1000, 1000), r4(0, 0, 23, 24), p4(1023, 0, 1023, 1023), 1};
        tbl[3] = '{p4(5, 5, 100, 0), r4(-5, -6, -50, 1023), p4(0, 0, 50, 1023), 1};
        tbl[4] = '{p4(0, 1023, 512, 256), r4(-1, 1, -512, -257), p4(0, 1023, 0, 0), 3};
        tbl[5] = '{p4(7, 900, 1, 1022), r4(1016, -900, -1, 1), p4(1023, 0, 0, 1023), 0};
        tbl[6] = '{p4(300, 301, 302, 303), r4(0, 10, -100, 720), p4(300, 311, 202, 1023), 0};
        tbl[7] = '{p4(1023, 1023, 0, 0), r4(32767, -32768, 32767, -32768), p4(1023, 0, 1023, 0), 4};

        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 8x8 constant block, full rate
        for (int i = 0; i < 16; i++) begin
            q_pred.push_back(p4(512, 512, 512, 512));
            q_res.push_back(r4(3, 3, 3, 3));
            q_exp.push_back({(i == 15), p4(515, 515, 515, 515)});
        end
        run_block("blk8x8", 8, 8, 0, -1, 0);

        // Table vectors as two 4x4 blocks
        for (int b = 0; b < 2; b++) begin
            clips = 0;
            for (int i = 0; i < 4; i++) begin
                q_pred.push_back(tbl[b*4+i].pred);
                q_res.push_back(tbl[b*4+i].res);
                q_exp.push_back({(i == 3), tbl[b*4+i].exp});
                clips += tbl[b*4+i].clips;
            end
            run_block($sformatf("table%0d", b), 4, 4, b, -1, clips);
        end

        // Randomized blocks
        fill_random(4, clips);
        run_block("bp4x4", 4, 4, 1, -1, clips);
        fill_random(32, clips);
        run_block("rnd16x8", 16, 8, 1, -1, clips);
        fill_random(64, clips);
        run_block("rnd4x64", 4, 64, 0, -1, clips);
        fill_random(16, clips);
        run_block("rnd64x1_4", 4, 16, 1, -1, clips);

        // Illegal sizes
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; blk_w = 7'(bad_w[i]); blk_h = 7'(bad_h[i]);
            res_valid = 1'b1; pred_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            chk($sformatf("cfg_err_%0d", i), cfg_err, 1);
            chk($sformatf("cfg_busy_%0d", i), busy, 0);
            chk($sformatf("cfg_res_ready_%0d", i), res_ready, 0);
            @(negedge clk);
            #1;
            chk($sformatf("cfg_err_clear_%0d", i), cfg_err, 0);
            chk($sformatf("cfg_busy_after_%0d", i), busy, 0);
            res_valid = 1'b0; pred_valid = 1'b0;
        end

        // Reset at beat 100 of a 64x64 block, then a normal 4x4 block
        fill_random(1024, clips);
        run_block("abort", 64, 64, 0, 100, 0);
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(4, clips);
        run_block("post_rst", 4, 4, 0, -1, clips);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
